// File: rtl/l1_mem_arbiter_pkg.sv
// Types shared by the L1 memory arbiter and its read-tag FIFO.
package cva5_types;

  typedef enum logic {
    L1_DCACHE = 1'b0,
    L1_ICACHE = 1'b1
  } l1_id_t;

  typedef struct packed {
    l1_id_t     id;
    logic [4:0] rlen;
  } l1_rd_tag_t;

  function automatic l1_id_t l1_other(input l1_id_t id);
    return (id == L1_DCACHE) ? L1_ICACHE : L1_DCACHE;
  endfunction

endpackage

// File: rtl/l1_mem_arbiter_rd_tag_fifo.sv
// In-order FIFO of accepted read bursts; head is a registered slot read combinationally.
module l1_rd_tag_fifo
  import cva5_types::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = $bits(l1_rd_tag_t)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [AW:0]      count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: only slots below count_q are ever observed.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full_o));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop_i && empty_o));

endmodule

// File: rtl/l1_mem_arbiter.sv
// Round-robin arbiter sharing one L1 memory port between dcache and icache, with read-beat routing.
module l1_mem_arbiter
  import cva5_types::*;
#(
  parameter int RD_TAGS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        d_request,
  input  logic [29:0] d_addr,
  input  logic        d_rnw,
  input  logic [4:0]  d_rlen,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wbe,
  output logic        d_ack,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_write_outstanding,
  input  logic        i_request,
  input  logic [29:0] i_addr,
  input  logic [4:0]  i_rlen,
  output logic        i_ack,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        m_request,
  output logic [29:0] m_addr,
  output logic        m_rnw,
  output logic [4:0]  m_rlen,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wbe,
  input  logic        m_ack,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  input  logic        m_write_outstanding
);
  l1_id_t     gnt_id, rr_last_q, rr_last_d, lock_id_q, lock_id_d;
  logic       lock_q, lock_d;
  logic [4:0] beat_q, beat_d;
  logic       tag_full, tag_empty, d_elig, i_elig, accept, beat_valid, last_beat;
  l1_rd_tag_t push_tag, head_tag;
  logic [$bits(l1_rd_tag_t)-1:0] head_raw;

  // Full is the registered count only, so a pop this cycle does not free a slot until next cycle.
  assign d_elig = d_request & (~d_rnw | ~tag_full);
  assign i_elig = i_request & ~tag_full;

  always_comb begin
    gnt_id = L1_DCACHE;
    if (lock_q)               gnt_id = lock_id_q;
    else if (d_elig && i_elig) gnt_id = l1_other(rr_last_q);
    else if (i_elig)          gnt_id = L1_ICACHE;
  end

  always_comb begin
    m_request = d_elig;
    m_addr    = d_addr;
    m_rnw     = d_rnw;
    m_rlen    = d_rlen;
    m_wdata   = d_wdata;
    m_wbe     = d_wbe;
    if (gnt_id == L1_ICACHE) begin
      m_request = i_elig;
      m_addr    = i_addr;
      m_rnw     = 1'b1;
      m_rlen    = i_rlen;
      m_wdata   = '0;
      m_wbe     = '0;
    end
  end

  assign accept = m_request & m_ack;
  assign d_ack  = accept & (gnt_id == L1_DCACHE);
  assign i_ack  = accept & (gnt_id == L1_ICACHE);

  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    rr_last_d = rr_last_q;
    if (accept) begin
      lock_d    = 1'b0;
      rr_last_d = gnt_id;
    end else if (m_request) begin
      lock_d    = 1'b1;
      lock_id_d = gnt_id;
    end
  end

  assign push_tag   = '{id: gnt_id, rlen: m_rlen};
  assign head_tag   = l1_rd_tag_t'(head_raw);
  assign beat_valid = m_rvalid & ~tag_empty;
  assign last_beat  = beat_valid & (beat_q == head_tag.rlen);
  assign beat_d     = !beat_valid ? beat_q : (last_beat ? 5'd0 : beat_q + 5'd1);

  assign d_rvalid = beat_valid & (head_tag.id == L1_DCACHE);
  assign i_rvalid = beat_valid & (head_tag.id == L1_ICACHE);
  assign d_rdata  = m_rdata;
  assign i_rdata  = m_rdata;
  assign d_write_outstanding = m_write_outstanding;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_id_q <= L1_DCACHE;
      rr_last_q <= L1_ICACHE;
      beat_q    <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      rr_last_q <= rr_last_d;
      beat_q    <= beat_d;
    end
  end

  l1_rd_tag_fifo #(.DEPTH(RD_TAGS), .WIDTH($bits(l1_rd_tag_t))) u_rd_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept & m_rnw),
    .wdata_i (push_tag),
    .pop_i   (last_beat),
    .head_o  (head_raw),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  a_rvalid_not_empty: assert property (@(posedge clk) disable iff (!rst_n) m_rvalid |-> !tag_empty);
  a_d_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (d_request && !d_ack) |=> (d_request && $stable({d_addr, d_rnw, d_rlen, d_wdata, d_wbe})));
  a_i_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (i_request && !i_ack) |=> (i_request && $stable({i_addr, i_rlen})));

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Self-checking bench: directed scenarios plus a randomized run against a queue-based model.
module tb_l1_mem_arbiter;
  logic        clk = 1'b0, rst_n;
  logic        d_request, d_rnw, d_ack, d_rvalid, d_write_outstanding;
  logic [29:0] d_addr, i_addr, m_addr;
  logic [4:0]  d_rlen, i_rlen, m_rlen;
  logic [31:0] d_wdata, d_rdata, i_rdata, m_wdata, m_rdata;
  logic [3:0]  d_wbe, m_wbe;
  logic        i_request, i_ack, i_rvalid;
  logic        m_request, m_rnw, m_ack, m_rvalid, m_write_outstanding;
  int checks = 0, failures = 0;

  l1_mem_arbiter #(.RD_TAGS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_request(d_request), .d_addr(d_addr), .d_rnw(d_rnw), .d_rlen(d_rlen),
    .d_wdata(d_wdata), .d_wbe(d_wbe), .d_ack(d_ack), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_write_outstanding(d_write_outstanding),
    .i_request(i_request), .i_addr(i_addr), .i_rlen(i_rlen), .i_ack(i_ack),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .m_request(m_request), .m_addr(m_addr), .m_rnw(m_rnw), .m_rlen(m_rlen),
    .m_wdata(m_wdata), .m_wbe(m_wbe), .m_ack(m_ack), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata), .m_write_outstanding(m_write_outstanding)
  );

  always #5 clk = ~clk;

  task automatic idle();
    d_request = 0; d_addr = '0; d_rnw = 0; d_rlen = '0; d_wdata = '0; d_wbe = '0;
    i_request = 0; i_addr = '0; i_rlen = '0;
    m_ack = 0; m_rvalid = 0; m_rdata = '0; m_write_outstanding = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle();
    m_ack = 1;
    @(negedge clk); #1;
    checks++; if (m_request !== 1'b0) begin failures++; $display("FAIL reset_m_request got=%b exp=0", m_request); end
    checks++; if (d_ack !== 1'b0 || i_ack !== 1'b0) begin failures++; $display("FAIL reset_acks got=%b%b exp=00", d_ack, i_ack); end
    checks++; if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b%b exp=00", d_rvalid, i_rvalid); end
    do_reset();
  endtask

  task automatic test_d_read_burst();
    do_reset();
    @(negedge clk);
    d_request = 1; d_rnw = 1; d_rlen = 7; d_addr = 30'h1234567; m_ack = 1; #1;
    checks++; if ({m_request, m_rnw, m_rlen, m_addr} !== {1'b1, 1'b1, 5'd7, 30'h1234567})
      begin failures++; $display("FAIL dread_mreq got=%b %b %0d %h", m_request, m_rnw, m_rlen, m_addr); end
    checks++; if ({d_ack, i_ack} !== 2'b10) begin failures++; $display("FAIL dread_ack got=%b%b exp=10", d_ack, i_ack); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      idle(); m_rvalid = 1; m_rdata = 32'hA000_0000 + k; #1;
      checks++; if ({d_rvalid, i_rvalid} !== 2'b10 || d_rdata !== 32'hA000_0000 + k)
        begin failures++; $display("FAIL dread_beat%0d got=%b%b %h exp=10 %h", k, d_rvalid, i_rvalid, d_rdata, 32'hA000_0000 + k); end
    end
    @(negedge clk); idle();
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      d_request = 1; d_rnw = 0; d_addr = 30'h100; d_wdata = 32'hDEAD_BEEF; d_wbe = 4'hF;
      i_request = (k < 4); i_addr = 30'h200; i_rlen = 0; m_ack = 1; #1;
      checks++; if ({d_ack, i_ack} !== ((k % 2 == 0) ? 2'b10 : 2'b01))
        begin failures++; $display("FAIL rr_grant%0d got=%b%b exp_dcache=%0d", k, d_ack, i_ack, (k % 2 == 0)); end
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); idle(); m_rvalid = 1; #1;
      checks++; if ({d_rvalid, i_rvalid} !== 2'b01) begin failures++; $display("FAIL rr_drain%0d got=%b%b exp=01", k, d_rvalid, i_rvalid); end
    end
    @(negedge clk); idle();
  endtask

  task automatic test_write_lock();
    do_reset();
    @(negedge clk);
    m_write_outstanding = 1;
    d_request = 1; d_rnw = 0; d_addr = 30'h11; d_wdata = 32'h1111_1111; d_wbe = 4'h3; m_ack = 1; #1;
    checks++; if (d_ack !== 1'b1) begin failures++; $display("FAIL wl_first_ack got=%b exp=1", d_ack); end
    checks++; if (d_write_outstanding !== 1'b1) begin failures++; $display("FAIL wl_wout got=%b exp=1", d_write_outstanding); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      d_addr = 30'h22; d_wdata = 32'h2222_2222; d_wbe = 4'hC; m_ack = 0;
      i_request = (k > 0); i_addr = 30'h33; i_rlen = 0; #1;
      checks++; if ({m_request, m_rnw, m_addr, m_wdata, m_wbe} !== {1'b1, 1'b0, 30'h22, 32'h2222_2222, 4'hC})
        begin failures++; $display("FAIL wl_locked%0d got=%b %b %h %h", k, m_request, m_rnw, m_addr, m_wdata); end
      checks++; if ({d_ack, i_ack} !== 2'b00) begin failures++; $display("FAIL wl_noack%0d got=%b%b exp=00", k, d_ack, i_ack); end
    end
    @(negedge clk); m_ack = 1; #1;
    checks++; if ({d_ack, i_ack, m_addr} !== {2'b10, 30'h22}) begin failures++; $display("FAIL wl_release got=%b%b %h", d_ack, i_ack, m_addr); end
    @(negedge clk); d_request = 0; #1;
    checks++; if ({i_ack, m_rnw, m_addr} !== {2'b11, 30'h33}) begin failures++; $display("FAIL wl_icache got=%b %b %h", i_ack, m_rnw, m_addr); end
    @(negedge clk); idle(); m_rvalid = 1; #1;
    checks++; if ({d_rvalid, i_rvalid} !== 2'b01) begin failures++; $display("FAIL wl_ibeat got=%b%b exp=01", d_rvalid, i_rvalid); end
    @(negedge clk); idle();
  endtask

  task automatic test_interleave();
    do_reset();
    @(negedge clk); d_request = 1; d_rnw = 1; d_rlen = 3; d_addr = 30'h40; m_ack = 1; #1;
    checks++; if (d_ack !== 1'b1) begin failures++; $display("FAIL il_dack got=%b exp=1", d_ack); end
    @(negedge clk); d_request = 0; i_request = 1; i_addr = 30'h50; i_rlen = 0; #1;
    checks++; if (i_ack !== 1'b1) begin failures++; $display("FAIL il_iack got=%b exp=1", i_ack); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); idle(); m_rvalid = 1; m_rdata = 32'h5000 + k; #1;
      checks++; if ({d_rvalid, i_rvalid} !== ((k < 4) ? 2'b10 : 2'b01))
        begin failures++; $display("FAIL il_beat%0d got=%b%b exp_dcache=%0d", k, d_rvalid, i_rvalid, (k < 4)); end
    end
    @(negedge clk); idle();
  endtask

  task automatic test_tag_full();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); idle();
      d_request = (k % 2 == 0); d_rnw = 1; d_rlen = 1; d_addr = 30'h60;
      i_request = (k % 2 == 1); i_addr = 30'h70; i_rlen = 1; m_ack = 1; #1;
      checks++; if ((d_ack | i_ack) !== 1'b1) begin failures++; $display("FAIL tf_fill%0d got=%b%b exp_ack=1", k, d_ack, i_ack); end
    end
    @(negedge clk); idle(); i_request = 1; i_addr = 30'h71; i_rlen = 1; m_ack = 1; #1;
    checks++; if ({m_request, i_ack} !== 2'b00) begin failures++; $display("FAIL tf_iblocked got=%b%b exp=00", m_request, i_ack); end
    @(negedge clk); d_request = 1; d_rnw = 0; d_addr = 30'h61; d_wdata = 32'h77; d_wbe = 4'h1; #1;
    checks++; if ({m_request, m_rnw, d_ack, i_ack} !== 4'b1010) begin failures++; $display("FAIL tf_write got=%b%b%b%b exp=1010", m_request, m_rnw, d_ack, i_ack); end
    @(negedge clk); d_rnw = 1; d_rlen = 1; d_addr = 30'h62; d_wdata = '0; d_wbe = '0; m_rvalid = 1; #1;
    checks++; if ({m_request, d_rvalid} !== 2'b01) begin failures++; $display("FAIL tf_beat0 got=%b%b exp=01", m_request, d_rvalid); end
    @(negedge clk); #1;
    checks++; if ({m_request, d_rvalid} !== 2'b01) begin failures++; $display("FAIL tf_lastbeat got=%b%b exp=01", m_request, d_rvalid); end
    @(negedge clk); m_rvalid = 0; #1;
    checks++; if ({m_request, i_ack, d_ack} !== 3'b110) begin failures++; $display("FAIL tf_resume got=%b%b%b exp=110", m_request, i_ack, d_ack); end
    @(negedge clk); idle();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    @(negedge clk); d_request = 1; d_rnw = 1; d_rlen = 7; d_addr = 30'h80; m_ack = 1; #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); idle(); m_rvalid = 1; #1;
      checks++; if (d_rvalid !== 1'b1) begin failures++; $display("FAIL rm_beat%0d got=%b exp=1", k, d_rvalid); end
    end
    rst_n = 0; #1;
    checks++; if ({m_request, d_ack, i_ack, d_rvalid, i_rvalid} !== 5'b0)
      begin failures++; $display("FAIL rm_async got=%b%b%b%b%b exp=00000", m_request, d_ack, i_ack, d_rvalid, i_rvalid); end
    m_rvalid = 0;
    @(negedge clk); rst_n = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); i_request = 1; i_addr = 30'h90; i_rlen = 0; m_ack = 1; #1;
      checks++; if (i_ack !== ((k < 4) ? 1'b1 : 1'b0)) begin failures++; $display("FAIL rm_refill%0d got=%b exp=%0d", k, i_ack, (k < 4)); end
    end
  endtask

  typedef struct { bit id; int rlen; } mtag_t;

  task automatic test_random();
    mtag_t q[$];
    int beat = 0;
    bit rr_last = 1, lock = 0, lock_id = 0, d_pend = 0, i_pend = 0;
    bit de, ie, g, exp_req;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (!d_pend) begin
        d_request = 0;
        if ($urandom_range(0, 2) == 0) begin
          d_request = 1; d_pend = 1; d_rnw = 1'($urandom_range(0, 1)); d_rlen = 5'($urandom_range(0, 3));
          d_addr = 30'($urandom); d_wdata = $urandom; d_wbe = 4'($urandom);
        end
      end
      if (!i_pend) begin
        i_request = 0;
        if ($urandom_range(0, 2) == 0) begin
          i_request = 1; i_pend = 1; i_rlen = 5'($urandom_range(0, 3)); i_addr = 30'($urandom);
        end
      end
      m_ack = 1'($urandom_range(0, 1));
      m_rvalid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      m_rdata = $urandom;
      m_write_outstanding = 1'($urandom_range(0, 1));
      #1;
      de = d_request && (!d_rnw || q.size() < 4);
      ie = i_request && (q.size() < 4);
      if (lock) g = lock_id;
      else if (de && ie) g = !rr_last;
      else g = ie && !de;
      exp_req = g ? ie : de;
      checks++; if (m_request !== exp_req) begin failures++; $display("FAIL rnd_mreq c=%0d got=%b exp=%b", c, m_request, exp_req); end
      if (exp_req) begin
        checks++;
        if (g ? ({m_addr, m_rnw, m_rlen} !== {i_addr, 1'b1, i_rlen})
              : ({m_addr, m_rnw} !== {d_addr, d_rnw} || (d_rnw ? m_rlen !== d_rlen : {m_wdata, m_wbe} !== {d_wdata, d_wbe})))
          begin failures++; $display("FAIL rnd_mfields c=%0d got=%h %b %0d exp_icache=%b", c, m_addr, m_rnw, m_rlen, g); end
      end
      checks++; if ({d_ack, i_ack} !== {exp_req && m_ack && !g, exp_req && m_ack && g})
        begin failures++; $display("FAIL rnd_ack c=%0d got=%b%b exp_req=%b icache=%b", c, d_ack, i_ack, exp_req, g); end
      checks++; if ({d_rvalid, i_rvalid} !== {m_rvalid && !q[0].id, m_rvalid && q[0].id})
        begin failures++; $display("FAIL rnd_rvalid c=%0d got=%b%b", c, d_rvalid, i_rvalid); end
      if (m_rvalid) begin
        checks++; if ((q[0].id ? i_rdata : d_rdata) !== m_rdata) begin failures++; $display("FAIL rnd_rdata c=%0d exp=%h", c, m_rdata); end
      end
      checks++; if (d_write_outstanding !== m_write_outstanding) begin failures++; $display("FAIL rnd_wout c=%0d got=%b", c, d_write_outstanding); end
      if (m_rvalid) begin
        if (beat == q[0].rlen) begin void'(q.pop_front()); beat = 0; end
        else beat++;
      end
      if (exp_req && m_ack) begin
        if (g) begin q.push_back('{1, int'(i_rlen)}); i_pend = 0; end
        else begin if (d_rnw) q.push_back('{0, int'(d_rlen)}); d_pend = 0; end
        rr_last = g; lock = 0;
      end else if (exp_req) begin
        lock = 1; lock_id = g;
      end
    end
    do_reset();
  endtask

  initial begin
    idle();
    test_reset();
    test_d_read_burst();
    test_round_robin();
    test_write_lock();
    test_interleave();
    test_tag_full();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
